avalon_rsa_dma: RTL

- Parametrised Avalon-MM DMA front end for a byte-serial modular-exponentiation core (rsa_core-style we/oe/start/reg_sel/addr port).
- Software programs source/destination base, block count and control via a CSR slave. The block fetches modulus and exponent words, then streams COUNT message words through the core and writes each result word back.
- Sits between the PCIe/DDR Avalon-MM fabric and a core instantiated outside this module (core ports are exposed).
- Adds over the previous generation: programmable addresses and block count, abort, progress counter, done interrupt and width generalisation.

---
 rtl/avalon_rsa_dma.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/avalon_rsa_dma.sv
// CSR-programmed Avalon-MM DMA that feeds operand words byte-serially into a modexp core and writes results back.
// One outstanding master read; read/write requests hold while avm_m0_waitrequest is high; CSR reads return 1 cycle later.
module avalon_rsa_dma #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  localparam int NB    = DATA_W / 8,
  localparam int BA_W  = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avm_m0_waitrequest,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_read,
  output logic              avm_m0_write,
  input  logic              avm_m0_readdatavalid,
  input  logic [DATA_W-1:0] avm_m0_readdata,
  output logic [DATA_W-1:0] avm_m0_writedata,
  input  logic [2:0]        avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  input  logic [31:0]       avs_s0_writedata,
  output logic [31:0]       avs_s0_readdata,
  output logic              avs_s0_waitrequest,
  output logic              irq,
  output logic              core_we,
  output logic              core_oe,
  output logic              core_start,
  output logic [1:0]        core_reg_sel,
  output logic [BA_W-1:0]   core_addr,
  output logic [7:0]        core_data_i,
  input  logic [7:0]        core_data_o,
  input  logic              core_ready
);
  localparam int CW = BA_W + 1;
  localparam logic [CW-1:0] NB_C   = CW'(NB);
  localparam logic [CW-1:0] LAST_C = CW'(NB - 1);
  localparam logic [1:0] SEL_MSG = 2'b01, SEL_MOD = 2'b10, SEL_EXP = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_LOAD, S_START, S_CALC, S_UNLOAD, S_WR} state_t;

  state_t            state_q, state_d;
  logic              irq_en_q, irq_en_d, done_q, done_d, aborted_q, aborted_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  count_q, count_d, progress_q, progress_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_m1;
  logic              abort_pend_q, abort_pend_d, calc_hold_q, calc_hold_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busy, ctrl_wr, start_req, abort_req;

  assign busy      = (state_q != S_IDLE);
  assign ctrl_wr   = avs_s0_write && (avs_s0_address == 3'd0);
  assign start_req = ctrl_wr && avs_s0_writedata[0];
  assign abort_req = abort_pend_q || (ctrl_wr && avs_s0_writedata[1] && busy);
  assign cnt_m1    = cnt_q - 1'b1;

  always_comb begin
    state_d      = state_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    src_d        = src_q;
    dst_d        = dst_q;
    count_d      = count_q;
    progress_d   = progress_q;
    addr_d       = addr_q;
    wr_addr_d    = wr_addr_q;
    sel_d        = sel_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    calc_hold_d  = calc_hold_q;
    abort_pend_d = abort_req;
    rdata_d      = '0;

    if (avs_s0_write) begin
      case (avs_s0_address)
        3'd0: irq_en_d = avs_s0_writedata[2];
        3'd1: begin
          if (avs_s0_writedata[1]) done_d = 1'b0;
          if (avs_s0_writedata[2]) aborted_d = 1'b0;
        end
        3'd2: if (!busy) src_d = ADDR_W'(avs_s0_writedata);
        3'd3: if (!busy) dst_d = ADDR_W'(avs_s0_writedata);
        3'd4: if (!busy) count_d = CNT_W'(avs_s0_writedata);
        default: ;
      endcase
    end

    if (avs_s0_read) begin
      case (avs_s0_address)
        3'd0:    rdata_d = {29'd0, irq_en_q, 2'b00};
        3'd1:    rdata_d = {29'd0, aborted_q, done_q, busy};
        3'd2:    rdata_d = 32'(src_q);
        3'd3:    rdata_d = 32'(dst_q);
        3'd4:    rdata_d = 32'(count_q);
        3'd5:    rdata_d = 32'(progress_q);
        default: rdata_d = '0;
      endcase
    end

    // FSM status updates come after the CSR writes so an internal set beats a same-cycle clear.
    case (state_q)
      S_IDLE: if (start_req) begin
        if (count_q != '0) begin
          done_d     = 1'b0;
          progress_d = '0;
          addr_d     = src_q;
          wr_addr_d  = dst_q;
          sel_d      = SEL_MOD;
          state_d    = S_RD;
        end else begin
          done_d = 1'b1;
        end
      end
      S_RD: if (!avm_m0_waitrequest) state_d = S_RWAIT;
      S_RWAIT: if (avm_m0_readdatavalid) begin
        if (abort_req) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          word_d  = avm_m0_readdata;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: if (abort_req) begin
        state_d   = S_IDLE;
        aborted_d = 1'b1;
      end else if (cnt_q == LAST_C) begin
        cnt_d = '0;
        case (sel_q)
          SEL_MOD: begin sel_d = SEL_EXP; addr_d = addr_q + ADDR_W'(NB); state_d = S_RD; end
          SEL_EXP: begin sel_d = SEL_MSG; addr_d = addr_q + ADDR_W'(NB); state_d = S_RD; end
          default: state_d = S_START;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_START: if (abort_req) begin
        state_d   = S_IDLE;
        aborted_d = 1'b1;
      end else begin
        calc_hold_d = 1'b1;
        state_d     = S_CALC;
      end
      S_CALC: begin
        calc_hold_d = 1'b0;
        if (abort_req) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (!calc_hold_q && core_ready) begin
          cnt_d   = '0;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: if (abort_req) begin
        state_d   = S_IDLE;
        aborted_d = 1'b1;
      end else begin
        // Core data lags the address by one cycle, so slot k captures byte k-1.
        if (cnt_q != '0) word_d[{cnt_m1[BA_W-1:0], 3'b000} +: 8] = core_data_o;
        if (cnt_q == NB_C) state_d = S_WR;
        else cnt_d = cnt_q + 1'b1;
      end
      S_WR: if (!avm_m0_waitrequest) begin
        progress_d = progress_q + 1'b1;
        wr_addr_d  = wr_addr_q + ADDR_W'(NB);
        if (abort_req) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (progress_d == count_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(NB);
          sel_d   = SEL_MSG;
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) abort_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      count_q      <= '0;
      progress_q   <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      sel_q        <= '0;
      word_q       <= '0;
      cnt_q        <= '0;
      abort_pend_q <= 1'b0;
      calc_hold_q  <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      count_q      <= count_d;
      progress_q   <= progress_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      sel_q        <= sel_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      abort_pend_q <= abort_pend_d;
      calc_hold_q  <= calc_hold_d;
      rdata_q      <= rdata_d;
    end
  end

  assign avm_m0_read        = (state_q == S_RD);
  assign avm_m0_write       = (state_q == S_WR);
  assign avm_m0_address     = avm_m0_write ? wr_addr_q : (avm_m0_read ? addr_q : '0);
  assign avm_m0_writedata   = avm_m0_write ? word_q : '0;
  assign avs_s0_readdata    = rdata_q;
  assign avs_s0_waitrequest = 1'b0;
  assign irq                = done_q & irq_en_q;
  assign core_we            = (state_q == S_LOAD);
  assign core_oe            = (state_q == S_UNLOAD) && (cnt_q != NB_C);
  assign core_start         = (state_q == S_START);
  assign core_reg_sel       = (core_we || state_q == S_UNLOAD) ? sel_q : 2'b00;
  assign core_addr          = (core_we || core_oe) ? cnt_q[BA_W-1:0] : '0;
  assign core_data_i        = core_we ? word_q[{cnt_q[BA_W-1:0], 3'b000} +: 8] : 8'h00;
endmodule
